// File: rtl/telemetry_pkg.sv
// Shared constants, FSM encoding and frame-length helper for the telemetry UART.
package telemetry_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, GAP} state_t;

  // Bytes per frame: two sync, count, payload, jack, checksum.
  function automatic int frame_bytes(input int w, input int n_ch);
    return 5 + (n_ch * w) / 8;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, DIV clocks per bit.
// Ready rises in the last stop-bit clock so a queued byte follows without an idle gap.
module uart_tx_byte #(
  parameter int DIV = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       tx_o
);

  localparam int            TW     = $clog2(DIV);
  localparam logic [TW-1:0] T_LOAD = TW'(DIV - 1);

  logic          r_active;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_timer == '0);
  assign ready_o   = !r_active || (w_bit_end && r_bit == 4'd9);
  assign tx_o      = r_tx;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_timer  <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else if (valid_i && ready_o) begin
      r_active <= 1'b1;
      r_timer  <= T_LOAD;
      r_bit    <= '0;
      r_shift  <= {1'b1, data_i};
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (!w_bit_end) begin
        r_timer <= r_timer - 1'b1;
      end else if (r_bit == 4'd9) begin
        r_active <= 1'b0;
      end else begin
        r_timer <= T_LOAD;
        r_bit   <= r_bit + 1'b1;
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
      end
    end
  end

endmodule

// File: rtl/telemetry_uart.sv
// Snapshots N_CH signed channels plus the jack byte on start_i and streams them as a
// checksummed 8N1 frame: A5 5A CNT payload JACK CHK, followed by a mark gap.
module telemetry_uart
  import telemetry_pkg::*;
#(
  parameter int W        = 16,
  parameter int N_CH     = 4,
  parameter int DIV      = 12,
  parameter int GAP_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [N_CH*W-1:0] ch_i,
  input  logic [7:0]      jack_i,
  output logic            tx_o,
  output logic            busy_o,
  output logic            drop_o,
  output logic [7:0]      frame_cnt_o
);

  localparam int NB   = frame_bytes(W, N_CH);
  localparam int BPS  = W / 8;
  localparam int NPAY = N_CH * BPS;
  localparam int IW   = $clog2(NB);
  localparam int TW   = $clog2(GAP_BITS * DIV);

  if (W % 8 != 0 || W < 8 || W > 32) begin : g_bad_w
    $error("telemetry_uart: W must be a multiple of 8 in 8..32");
  end
  if (DIV < 2) begin : g_bad_div
    $error("telemetry_uart: DIV must be at least 2");
  end
  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("telemetry_uart: N_CH must be in 1..8");
  end
  if (GAP_BITS < 1) begin : g_bad_gap
    $error("telemetry_uart: GAP_BITS must be at least 1");
  end

  state_t             r_state;
  logic [TW-1:0]      r_timer;
  logic [3:0]         r_bit;
  logic [IW-1:0]      r_idx;
  logic [NPAY*8-1:0]  r_pay;
  logic [7:0]         r_jack;
  logic [7:0]         r_chk;
  logic [7:0]         r_cnt;
  logic               r_busy;

  logic [NPAY*8-1:0]  w_snap;
  logic [IW-1:0]      w_idx;
  logic [7:0]         w_byte;
  logic               w_valid;
  logic               w_ready;
  logic               w_fire;
  logic               w_last;

  // Payload reordered so the first transmitted byte (ch0 MSB) sits at the top.
  for (genvar j = 0; j < NPAY; j++) begin : g_snap
    assign w_snap[(NPAY-1-j)*8 +: 8] = ch_i[(j/BPS)*W + (BPS-1-(j%BPS))*8 +: 8];
  end

  assign w_last  = (r_idx == IW'(NB - 1));
  assign w_idx   = (r_state == LOAD) ? '0 : r_idx + 1'b1;
  assign w_valid = (r_state == LOAD) ||
                   (r_state == STOP && r_timer == '0 && !w_last);
  assign w_fire  = w_valid && w_ready;

  always_comb begin
    // NOTE: default first so every path assigns w_byte and no latch is inferred.
    w_byte = r_pay[NPAY*8-1 -: 8];
    if (w_idx == '0)                w_byte = SYNC0;
    else if (w_idx == IW'(1))       w_byte = SYNC1;
    else if (w_idx == IW'(2))       w_byte = r_cnt;
    else if (w_idx == IW'(NB - 2))  w_byte = r_jack;
    else if (w_idx == IW'(NB - 1))  w_byte = r_chk;
  end

  // NOTE: the snapshot registers are plain flops, so they are reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_pay   <= '0;
      r_jack  <= '0;
      r_chk   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_pay   <= w_snap;
          r_jack  <= jack_i;
          r_busy  <= 1'b1;
          r_state <= LOAD;
        end
        LOAD: begin
          r_chk <= '0;
          if (w_ready) begin
            r_state <= START;
            r_timer <= TW'(DIV - 1);
            r_bit   <= '0;
            r_idx   <= '0;
          end
        end
        START, DATA, STOP: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else if (r_bit != 4'd9) begin
            r_timer <= TW'(DIV - 1);
            r_bit   <= r_bit + 1'b1;
            r_state <= (r_bit == 4'd8) ? STOP : DATA;
          end else if (w_last) begin
            r_timer <= TW'(GAP_BITS * DIV - 1);
            r_state <= GAP;
          end else begin
            r_timer <= TW'(DIV - 1);
            r_bit   <= '0;
            r_idx   <= w_idx;
            r_state <= START;
          end
        end
        GAP: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Checksum covers CNT..JACK; payload advances as each channel byte is handed off.
      if (w_fire && w_idx >= IW'(3) && w_idx <= IW'(NB - 3)) r_pay <= r_pay << 8;
      if (w_fire && w_idx >= IW'(2) && w_idx <= IW'(NB - 2)) r_chk <= r_chk ^ w_byte;
    end
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (w_valid),
    .ready_o (w_ready),
    .data_i  (w_byte),
    .tx_o    (tx_o)
  );

  assign busy_o      = r_busy;
  assign drop_o      = start_i && r_busy;
  assign frame_cnt_o = r_cnt;

endmodule

// File: tb/tb_telemetry_uart.sv
// Self-checking bench: two instances (default and W=24/N_CH=1/DIV=4) compared against a
// byte-level frame model and the per-clock 8N1 waveform it implies.
module tb_telemetry_uart;

  localparam int WA = 16, NA = 4,   DA = 12, GA = 2;
  localparam int WB = 24, NBCH = 1, DB = 4,  GB = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start_a = 1'b0, start_b = 1'b0;
  logic [NA*WA-1:0]    ch_a = '0;
  logic [NBCH*WB-1:0]  ch_b = '0;
  logic [7:0]          jack_a = '0, jack_b = '0;
  logic                tx_a, busy_a, drop_a, tx_b, busy_b, drop_b;
  logic [7:0]          cnt_a, cnt_b;

  always #5 clk = ~clk;

  telemetry_uart #(.W(WA), .N_CH(NA), .DIV(DA), .GAP_BITS(GA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .ch_i(ch_a), .jack_i(jack_a),
    .tx_o(tx_a), .busy_o(busy_a), .drop_o(drop_a), .frame_cnt_o(cnt_a)
  );

  telemetry_uart #(.W(WB), .N_CH(NBCH), .DIV(DB), .GAP_BITS(GB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .ch_i(ch_b), .jack_i(jack_b),
    .tx_o(tx_b), .busy_o(busy_b), .drop_o(drop_b), .frame_cnt_o(cnt_b)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mcnt_a = '0, mcnt_b = '0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int which);
    return (which != 0) ? tx_b : tx_a;
  endfunction
  function automatic logic busy_of(input int which);
    return (which != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic drop_of(input int which);
    return (which != 0) ? drop_b : drop_a;
  endfunction
  function automatic logic [7:0] cnt_of(input int which);
    return (which != 0) ? cnt_b : cnt_a;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which != 0) start_b = v; else start_a = v;
  endtask

  task automatic scramble(input int which);
    if (which != 0) begin
      ch_b   = 24'($urandom());
      jack_b = 8'($urandom());
    end else begin
      ch_a   = {$urandom(), $urandom()};
      jack_a = 8'($urandom());
    end
  endtask

  // Reference frame: sync, count, big-endian channel bytes, jack, XOR of count..jack.
  function automatic void model_frame(input logic [255:0] ch, input int w, input int nch,
                                      input logic [7:0] cnt, input logic [7:0] jack);
    logic [7:0] chk, b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(cnt);
    chk = cnt;
    for (int k = 0; k < nch; k++) begin
      for (int j = w / 8 - 1; j >= 0; j--) begin
        b = ch[k*w + j*8 +: 8];
        exp_q.push_back(b);
        chk ^= b;
      end
    end
    exp_q.push_back(jack);
    chk ^= jack;
    exp_q.push_back(chk);
  endfunction

  // Called right after a negedge with the DUT idle; returns right after the negedge of the
  // cycle in which busy falls (or after reset release when rst_at fires).
  task automatic run_frame(input int which, input int mut_at, input int drop_at, input int rst_at);
    int         div, gap, nb, f, wave_err, gap_err, bi, p;
    logic       exp_bit;
    logic [7:0] cur, got_byte;
    logic       samp[$];
    div = (which != 0) ? DB : DA;
    gap = (which != 0) ? GB : GA;
    if (which != 0) model_frame(256'(ch_b), WB, NBCH, mcnt_b, jack_b);
    else            model_frame(256'(ch_a), WA, NA,   mcnt_a, jack_a);
    nb = exp_q.size();

    check("idle_before", 32'(busy_of(which)), 32'd0);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    check("busy_t1", 32'(busy_of(which)), 32'd1);
    check("tx_t1", 32'(tx_of(which)), 32'd1);

    f = 10 * nb * div;
    wave_err = 0;
    for (int c = 0; c < f; c++) begin
      @(negedge clk);
      samp.push_back(tx_of(which));
      bi  = c / (10 * div);
      p   = (c / div) % 10;
      cur = exp_q[bi];
      exp_bit = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : cur[p-1];
      if (tx_of(which) !== exp_bit || busy_of(which) !== 1'b1) wave_err++;
      if (c == mut_at) scramble(which);
      if (drop_at >= 0 && c == drop_at) begin
        set_start(which, 1'b1);
        #1 check("drop_pulse", 32'(drop_of(which)), 32'd1);
      end
      if (drop_at >= 0 && c == drop_at + 1) begin
        set_start(which, 1'b0);
        #1 check("drop_single", 32'(drop_of(which)), 32'd0);
      end
      if (rst_at >= 0 && c == rst_at) begin
        check("wave_pre_reset", 32'(wave_err), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_tx_async", 32'(tx_of(which)), 32'd1);
        check("rst_busy", 32'(busy_of(which)), 32'd0);
        check("rst_frame_cnt", 32'(cnt_of(which)), 32'd0);
        mcnt_a = '0;
        mcnt_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    check("start_bit_t2", 32'(samp[0]), 32'd0);
    check("waveform", 32'(wave_err), 32'd0);
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < 8; k++) got_byte[k] = samp[i*10*div + (1+k)*div + div/2];
      check($sformatf("byte%0d", i), 32'(got_byte), 32'(exp_q[i]));
    end

    gap_err = 0;
    for (int g = 0; g < gap * div; g++) begin
      @(negedge clk);
      if (tx_of(which) !== 1'b1 || busy_of(which) !== 1'b1) gap_err++;
    end
    check("gap", 32'(gap_err), 32'd0);
    @(negedge clk);
    check("busy_fall", 32'(busy_of(which)), 32'd0);
    if (which != 0) mcnt_b++; else mcnt_a++;
    check("frame_cnt", 32'(cnt_of(which)), 32'((which != 0) ? mcnt_b : mcnt_a));
  endtask

  initial begin
    int quiet_err;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("reset_tx_a", 32'(tx_a), 32'd1);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_cnt_a", 32'(cnt_a), 32'd0);
    check("reset_tx_b", 32'(tx_b), 32'd1);
    check("reset_drop_a", 32'(drop_a), 32'd0);

    // Directed frame, then two back-to-back randomized frames with mid-frame input changes.
    ch_a   = 64'h0000_0000_0000_1234;
    jack_a = 8'h00;
    run_frame(0, -1, -1, -1);
    scramble(0);
    run_frame(0, 0, -1, -1);
    scramble(0);
    run_frame(0, 700, -1, -1);
    check("cnt_after_three", 32'(cnt_a), 32'd3);

    // Request during DATA of byte 5 is dropped and never replayed.
    scramble(0);
    run_frame(0, -1, 5*10*DA + 3*DA, -1);
    quiet_err = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || tx_a !== 1'b1) quiet_err++;
    end
    check("no_replay", 32'(quiet_err), 32'd0);

    // Reset during the start bit of byte 3, then a clean frame restarting at CNT 00.
    scramble(0);
    run_frame(0, -1, -1, 3*10*DA + 2);
    @(negedge clk);
    scramble(0);
    run_frame(0, 40, -1, -1);

    // Narrow-parameter instance: directed vector, then a randomized frame with a drop.
    ch_b   = 24'h800001;
    jack_b = 8'h0F;
    run_frame(1, -1, -1, -1);
    scramble(1);
    run_frame(1, 10, 5*10*DB + 3*DB, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/telemetry_uart.md
# telemetry_uart

Parametrised, framed successor to the fixed-format debug UART. It snapshots `N_CH` signed sample channels plus the 8-bit jack-detect byte on a start strobe, such as the `sample_clk` edge. It then streams them as a checksummed 8N1 frame on a single TX pin. It sits beside `eurorack_pmod` in the `clk_256fs` domain and serves both bring-up and calibration capture.

## Interface
- `W`, 16: sample width in bits; must be a multiple of 8 (8..32).
- `N_CH`, 4: channel count (1..8).
- `DIV`, 12: clocks per UART bit (≥ 2).
- `GAP_BITS`, 2: minimum idle (mark) bit-times appended after each frame.
- `clk`  in  1: system clock (`clk_256fs`). One clock; reset is asynchronous and active-low.
- `rst_n`  in  1: asynchronous active-low reset.
- `start_i`  in  1: single-cycle frame request.
- `ch_i`  in  `N_CH*W`: channel samples; channel k occupies bits `[k*W +: W]`.
- `jack_i`  in  8: jack-detect byte.
- `tx_o`  out  1: UART TX, idle high.
- `busy_o`  out  1: high from accept through the end of the gap.
- `drop_o`  out  1: one-cycle pulse when `start_i` arrives while busy.
- `frame_cnt_o`  out  8: count of frames sent, wraps at 256.

## Operation
- Frame byte order:
  - `SYNC0` = 0xA5
  - `SYNC1` = 0x5A
  - CNT (current `frame_cnt_o`)
  - channel bytes: ch0..ch(N_CH-1), each big-endian (MSB byte first)
  - JACK
  - CHK
- Frame length is `NB = 5 + N_CH*W/8` bytes.
- CHK is the XOR of all bytes from CNT through JACK. The SYNC bytes are excluded.
- Byte framing: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly `DIV` clocks.
- Snapshot:
  - `ch_i` and `jack_i` are registered on the accept cycle.
  - Later input changes do not affect the frame in flight.
- FSM states:
  - IDLE: `start_i` → LOAD (accept).
  - LOAD: one cycle; latch the snapshot and clear the running CHK → START.
  - START: `DIV` cycles → DATA.
  - DATA: 8×`DIV` cycles → STOP.
  - STOP: `DIV` cycles; then next byte → START, or last byte → GAP.
  - GAP: `GAP_BITS`×`DIV` cycles → IDLE.
- Counter update: `frame_cnt_o` increments on GAP exit, so the next frame's CNT is one higher.
- Busy requests:
  - `start_i` while `busy_o`=1 is dropped: `drop_o` pulses the same cycle and no request is queued.
  - A `start_i` in the IDLE cycle right after GAP exit is accepted.
- Reset:
  - Values: `tx_o`=1, `busy_o`=0, `drop_o`=0, `frame_cnt_o`=0, FSM=IDLE, all shift and timer registers cleared.
  - Reset mid-frame forces `tx_o` high immediately (asynchronously). No partial-frame resume.

## Timing
- Accept at cycle t (IDLE, `start_i`=1):
  - `busy_o`=1 from t+1.
  - The SYNC0 start bit appears on `tx_o` at t+2 (LOAD at t+1).
- Frame duration from the first start bit: `10*NB*DIV` clocks, then `GAP_BITS*DIV` clocks of gap.
- `busy_o` falls in the cycle after the last gap clock. The earliest next accept is that cycle.
- Default example (`W`=16, `N_CH`=4, `DIV`=12, `GAP_BITS`=2):
  - `NB`=13 bytes, 1560 clocks of data plus a 24-clock gap.
  - The next accept is possible at t+1586.
- `tx_o` is driven from a register: no combinational path from inputs.
- The bit timer counts `DIV-1` down to 0. The bit counter runs 0..9 per byte. The byte index runs 0..`NB-1`.

## Structure
- `telemetry_pkg`:
  - `SYNC0`/`SYNC1` constants.
  - `state_t` enum {IDLE, LOAD, START, DATA, STOP, GAP}.
  - A function for `NB(W,N_CH)`.
- One sub-module, `uart_tx_byte`:
  - Parameter: `DIV`.
  - Ports: `clk`, `rst_n`, `valid_i`/`ready_o` byte handshake, `data_i[7:0]`, `tx_o`.
  - The top FSM sequences bytes, mux-selects the snapshot byte and accumulates CHK.
- Elaboration-time assertions: `W%8==0`, `DIV>=2`, `N_CH` in range.

## Test plan
- Reset, then idle 1000 clocks → `tx_o`=1, `busy_o`=0, `frame_cnt_o`=0.
- Default params; inputs ch0=0x1234, ch1..3=0, jack=0x00, one `start_i` → decoded bytes A5 5A 00 12 34 00 00 00 00 00 00 00 26. Start bit at t+2, each bit exactly 12 clocks, `busy_o` low at t+1586.
- Three back-to-back frames, each started on `busy_o` fall → CNT bytes 00, 01, 02; `frame_cnt_o`=3. Change `ch_i` mid-frame → the transmitted frame still carries the snapshot values.
- `start_i` pulsed during DATA of byte 5 → `drop_o` single pulse; frame unaltered; no second frame follows.
- Deassert `rst_n` mid-byte → `tx_o`=1 within the same cycle. After release, a new `start_i` yields a full frame with CNT=00.
- Params `W`=24, `N_CH`=1, `DIV`=4; ch0=0x800001, jack=0x0F → bytes A5 5A 00 80 00 01 0F 8E. Frame length 80×4 clocks.
